// File: rtl/kch_table_selector.sv
// Cluster-head table: collects CH advertisements per round, then selects the best CH after an idle timeout.
// Latency: selection pulse TIMEOUT+1+N cycles after the last accepted advertisement (N = table entries).
// Backpressure: none; advertisements that cannot be stored (table/limit full or scan in progress) are dropped and flagged.
module kch_table_selector #(
  parameter int WORD_WIDTH = 16,
  parameter int CH_DEPTH   = 16,
  parameter int TIMEOUT    = 15,
  parameter int IDX_W      = $clog2(CH_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_KCH,
  input  logic                  HB_reset,
  input  logic [WORD_WIDTH-1:0] HB_CHlimit,
  input  logic [WORD_WIDTH-1:0] fCH_ID,
  input  logic [WORD_WIDTH-1:0] fCH_Hops,
  input  logic [WORD_WIDTH-1:0] fCH_QValue,
  output logic [WORD_WIDTH-1:0] chosenCH,
  output logic [WORD_WIDTH-1:0] hopsfromCH,
  output logic                  sel_valid,
  output logic                  adv_dropped,
  output logic [IDX_W:0]        kch_count,
  output logic                  busy
);

  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(TIMEOUT);
  localparam logic [IDX_W:0]   DEPTH_C  = (IDX_W + 1)'(CH_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SCAN} state_t;

  state_t                state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [IDX_W:0]        cnt_q, cnt_d;
  logic [IDX_W:0]        idx_q, idx_d;
  logic [CH_DEPTH-1:0]   vld_q, vld_d;
  logic [WORD_WIDTH-1:0] id_q   [CH_DEPTH];
  logic [WORD_WIDTH-1:0] id_d   [CH_DEPTH];
  logic [WORD_WIDTH-1:0] hops_q [CH_DEPTH];
  logic [WORD_WIDTH-1:0] hops_d [CH_DEPTH];
  logic [WORD_WIDTH-1:0] qv_q   [CH_DEPTH];
  logic [WORD_WIDTH-1:0] qv_d   [CH_DEPTH];
  logic [WORD_WIDTH-1:0] bid_q, bid_d, bhops_q, bhops_d, bqv_q, bqv_d;
  logic [WORD_WIDTH-1:0] chosen_q, chosen_d, hopsout_q, hopsout_d;
  logic                  sel_q, sel_d, drop_q, drop_d;

  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;
  logic                  room;
  logic [WORD_WIDTH-1:0] c_id, c_hops, c_qv;
  logic                  better;

  // Parallel ID match against all valid entries (IDs are unique, so at most one hit).
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < CH_DEPTH; i++) begin
      if (vld_q[i] && (id_q[i] == fCH_ID)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Live limit: table has room only below both the round limit and the physical depth.
  assign room = (cnt_q < DEPTH_C) && (WORD_WIDTH'(cnt_q) < HB_CHlimit);

  // Scan candidate and ranking: fewer hops, then higher Q, then lower ID.
  assign c_id   = id_q[idx_q[IDX_W-1:0]];
  assign c_hops = hops_q[idx_q[IDX_W-1:0]];
  assign c_qv   = qv_q[idx_q[IDX_W-1:0]];
  assign better = (c_hops < bhops_q) ||
                  ((c_hops == bhops_q) && (c_qv > bqv_q)) ||
                  ((c_hops == bhops_q) && (c_qv == bqv_q) && (c_id < bid_q));

  // Next-state, table update and output computation.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    vld_d     = vld_q;
    id_d      = id_q;
    hops_d    = hops_q;
    qv_d      = qv_q;
    bid_d     = bid_q;
    bhops_d   = bhops_q;
    bqv_d     = bqv_q;
    chosen_d  = chosen_q;
    hopsout_d = hopsout_q;
    sel_d     = 1'b0;
    drop_d    = 1'b0;
    if (HB_reset) begin
      state_d   = S_IDLE;
      timer_d   = TMR_INIT;
      cnt_d     = '0;
      idx_d     = '0;
      vld_d     = '0;
      chosen_d  = '0;
      hopsout_d = '1;
    end else begin
      case (state_q)
        S_IDLE, S_COLLECT: begin
          if (en_KCH && (hit || room)) begin
            if (hit) begin
              hops_d[hit_idx] = fCH_Hops;
              qv_d[hit_idx]   = fCH_QValue;
            end else begin
              vld_d[cnt_q[IDX_W-1:0]]  = 1'b1;
              id_d[cnt_q[IDX_W-1:0]]   = fCH_ID;
              hops_d[cnt_q[IDX_W-1:0]] = fCH_Hops;
              qv_d[cnt_q[IDX_W-1:0]]   = fCH_QValue;
              cnt_d = cnt_q + 1'b1;
            end
            timer_d = TMR_INIT;
            state_d = S_COLLECT;
          end else begin
            // A discarded advertisement counts as silence for the timeout.
            drop_d = en_KCH;
            if (state_q == S_COLLECT) begin
              if (timer_q != '0) begin
                timer_d = timer_q - 1'b1;
              end else begin
                state_d = S_SCAN;
                idx_d   = '0;
              end
            end
          end
        end
        S_SCAN: begin
          drop_d = en_KCH;
          if ((idx_q == '0) || better) begin
            bid_d   = c_id;
            bhops_d = c_hops;
            bqv_d   = c_qv;
          end
          idx_d = idx_q + 1'b1;
          if ((idx_q + 1'b1) >= cnt_q) begin
            chosen_d  = bid_d;
            hopsout_d = bhops_d;
            sel_d     = 1'b1;
            state_d   = S_IDLE;
            timer_d   = TMR_INIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= TMR_INIT;
      cnt_q     <= '0;
      idx_q     <= '0;
      vld_q     <= '0;
      chosen_q  <= '0;
      hopsout_q <= '1;
      sel_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      vld_q     <= vld_d;
      chosen_q  <= chosen_d;
      hopsout_q <= hopsout_d;
      sel_q     <= sel_d;
      drop_q    <= drop_d;
    end
  end

  // Table payload and running best; qualified by vld_q/state, so no reset needed.
  always_ff @(posedge clk) begin
    id_q    <= id_d;
    hops_q  <= hops_d;
    qv_q    <= qv_d;
    bid_q   <= bid_d;
    bhops_q <= bhops_d;
    bqv_q   <= bqv_d;
  end

  assign chosenCH    = chosen_q;
  assign hopsfromCH  = hopsout_q;
  assign sel_valid   = sel_q;
  assign adv_dropped = drop_q;
  assign kch_count   = cnt_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_kch_table_selector.sv
// Bench for kch_table_selector: directed advertisement sequences, an event-timeline model
// of the table/selection, a per-cycle compare process and hand-computed literal checks.
module tb_kch_table_selector;

  localparam int WW = 16;
  localparam int DEPTH = 16;
  localparam int TMO = 15;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          hb = 1'b0;
  logic [WW-1:0] limit = 16'hFFFF;
  logic [WW-1:0] fid = '0, fh = '0, fq = '0;
  logic [WW-1:0] chosenCH, hopsfromCH;
  logic          sel_valid, adv_dropped, busy;
  logic [IW:0]   kch_count;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  kch_table_selector #(.WORD_WIDTH(WW), .CH_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .en_KCH(en), .HB_reset(hb), .HB_CHlimit(limit),
    .fCH_ID(fid), .fCH_Hops(fh), .fCH_QValue(fq),
    .chosenCH(chosenCH), .hopsfromCH(hopsfromCH), .sel_valid(sel_valid),
    .adv_dropped(adv_dropped), .kch_count(kch_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- model: table as a queue, selection as timed events ----------------
  typedef struct {
    logic [WW-1:0] id;
    logic [WW-1:0] hops;
    logic [WW-1:0] q;
  } ent_t;

  ent_t          tbl[$];
  int            cyc = 0;
  int            scan_at = 0;
  bit            m_busy = 0;
  logic [WW-1:0] m_chosen = '0;
  logic [WW-1:0] m_hops = '1;
  bit            m_sel = 0;
  bit            m_drop = 0;

  task automatic model_clear();
    tbl.delete();
    m_busy   = 0;
    m_chosen = '0;
    m_hops   = '1;
    m_sel    = 0;
    m_drop   = 0;
  endtask

  task automatic model_step();
    int   hit;
    int   lim;
    bit   acc;
    ent_t e;
    logic [3*WW-1:0] key, bkey;
    cyc++;
    m_sel  = 0;
    m_drop = 0;
    if (hb) begin
      model_clear();
      return;
    end
    if (en) begin
      if (m_busy && cyc > scan_at) begin
        m_drop = 1;
      end else begin
        acc = 0;
        hit = -1;
        foreach (tbl[i]) if (tbl[i].id == fid) hit = i;
        lim = (int'(limit) < DEPTH) ? int'(limit) : DEPTH;
        if (hit >= 0) begin
          e = tbl[hit];
          e.hops = fh;
          e.q = fq;
          tbl[hit] = e;
          acc = 1;
        end else if (tbl.size() < lim) begin
          e.id = fid;
          e.hops = fh;
          e.q = fq;
          tbl.push_back(e);
          acc = 1;
        end else begin
          m_drop = 1;
        end
        if (acc) begin
          m_busy  = 1;
          scan_at = cyc + TMO + 1;
        end
      end
    end
    if (m_busy && cyc == scan_at + tbl.size()) begin
      // Best = smallest key {hops, inverted Q, id}.
      bkey = '1;
      foreach (tbl[i]) begin
        key = {tbl[i].hops, ~tbl[i].q, tbl[i].id};
        if (key < bkey) bkey = key;
      end
      m_chosen = bkey[WW-1:0];
      m_hops   = bkey[3*WW-1:2*WW];
      m_sel    = 1;
      m_busy   = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_clear();
    else model_step();
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("chosenCH", 32'(chosenCH), 32'(m_chosen));
      check("hopsfromCH", 32'(hopsfromCH), 32'(m_hops));
      check("sel_valid", 32'(sel_valid), 32'(m_sel));
      check("adv_dropped", 32'(adv_dropped), 32'(m_drop));
      check("kch_count", 32'(kch_count), 32'(tbl.size()));
      check("busy", 32'(busy), 32'(m_busy));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic adv(input logic [WW-1:0] i, input logic [WW-1:0] h, input logic [WW-1:0] q);
    en = 1'b1;
    fid = i;
    fh = h;
    fq = q;
    tick();
    en = 1'b0;
  endtask

  task automatic round_clear();
    hb = 1'b1;
    tick();
    hb = 1'b0;
  endtask

  // Counts cycles from now until sel_valid is seen; -1 if it never arrives.
  task automatic wait_sel(input string name, input int exp_k);
    int k;
    k = -1;
    for (int i = 1; i <= 60 && k < 0; i++) begin
      tick();
      if (sel_valid) k = i;
    end
    check(name, 32'(k), 32'(exp_k));
  endtask

  initial begin
    int seen;
    repeat (2) tick();
    rst = 1'b0;
    started = 1;
    // Reset state.
    check("rst_chosen", 32'(chosenCH), 32'd0);
    check("rst_hops", 32'(hopsfromCH), 32'hFFFF);
    check("rst_count", 32'(kch_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Three CHs: hops decides, then ID breaks the Q tie.
    adv(16'd5, 16'd2, 16'd10);
    adv(16'd3, 16'd1, 16'd4);
    adv(16'd9, 16'd1, 16'd4);
    check("t1_count", 32'(kch_count), 32'd3);
    wait_sel("t1_latency", 19);
    check("t1_chosen", 32'(chosenCH), 32'd3);
    check("t1_hops", 32'(hopsfromCH), 32'd1);
    tick();
    check("t1_pulse_len", 32'(sel_valid), 32'd0);

    // Hop tie, higher Q wins.
    round_clear();
    adv(16'd2, 16'd1, 16'd7);
    adv(16'd8, 16'd1, 16'd20);
    wait_sel("t2_latency", 18);
    check("t2_chosen", 32'(chosenCH), 32'd8);

    // Update in place.
    round_clear();
    adv(16'd4, 16'd3, 16'd5);
    repeat (3) tick();
    adv(16'd4, 16'd1, 16'd5);
    check("t3_count", 32'(kch_count), 32'd1);
    wait_sel("t3_latency", 17);
    check("t3_chosen", 32'(chosenCH), 32'd4);
    check("t3_hops", 32'(hopsfromCH), 32'd1);

    // Round limit of two entries.
    round_clear();
    limit = 16'd2;
    adv(16'd10, 16'd5, 16'd1);
    adv(16'd11, 16'd4, 16'd1);
    wait_sel("t4_latency", 18);
    adv(16'd12, 16'd0, 16'd0);
    check("t4_drop3", 32'(adv_dropped), 32'd1);
    adv(16'd13, 16'd0, 16'd0);
    check("t4_drop4", 32'(adv_dropped), 32'd1);
    check("t4_count", 32'(kch_count), 32'd2);
    repeat (20) tick();
    check("t4_chosen", 32'(chosenCH), 32'd11);
    check("t4_hops", 32'(hopsfromCH), 32'd4);

    // Fill the whole table, overflow by one, then advertise during the scan.
    round_clear();
    limit = 16'hFFFF;
    for (int i = 0; i < DEPTH; i++) adv(16'(100 + i), (i == 7) ? 16'd1 : 16'd5, 16'(i));
    adv(16'd200, 16'd0, 16'd0);
    check("t5_overflow_drop", 32'(adv_dropped), 32'd1);
    check("t5_count", 32'(kch_count), 32'd16);
    repeat (17) tick();
    adv(16'd201, 16'd0, 16'd0);
    check("t5_scan_drop", 32'(adv_dropped), 32'd1);
    wait_sel("t5_latency", 13);
    check("t5_chosen", 32'(chosenCH), 32'd107);
    check("t5_hops", 32'(hopsfromCH), 32'd1);

    // Round clear in the middle of a scan.
    round_clear();
    adv(16'd1, 16'd1, 16'd1);
    adv(16'd2, 16'd2, 16'd2);
    repeat (16) tick();
    check("t6_busy_scan", 32'(busy), 32'd1);
    hb = 1'b1;
    tick();
    hb = 1'b0;
    check("t6_count", 32'(kch_count), 32'd0);
    check("t6_chosen", 32'(chosenCH), 32'd0);
    check("t6_hops", 32'(hopsfromCH), 32'hFFFF);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sel_valid) seen++;
    end
    check("t6_no_sel", 32'(seen), 32'd0);

    // Asynchronous reset in the middle of collection.
    adv(16'd1, 16'd1, 16'd1);
    wait_sel("t7_pre_latency", 17);
    adv(16'd6, 16'd2, 16'd2);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("t7_chosen", 32'(chosenCH), 32'd0);
    check("t7_hops", 32'(hopsfromCH), 32'hFFFF);
    check("t7_count", 32'(kch_count), 32'd0);
    check("t7_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    adv(16'd7, 16'd3, 16'd3);
    wait_sel("t7_post_latency", 17);
    check("t7_post_chosen", 32'(chosenCH), 32'd7);
    check("t7_post_hops", 32'(hopsfromCH), 32'd3);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kch_table_selector.md
# kch_table_selector

Parametrised cluster-head (CH) table and selector for the EER-RL node controller. It stores up to CH_DEPTH distinct CH advertisements per heartbeat round and updates entries in place on repeated IDs. After an inactivity timeout it scans the table and selects the best CH by the hierarchy min hops > max Q-value > min node ID. The result feeds the node's join/route logic as chosenCH/hopsfromCH with a one-cycle valid pulse.

## Interface
- WORD_WIDTH, 16, width of ID, hop-count and Q-value fields
- CH_DEPTH, 16, number of table entries (power of two, ≥2)
- TIMEOUT, 15, idle cycles after last advertisement before selection
- IDX_W, $clog2(CH_DEPTH), derived index width (not overridden)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en_KCH  in  1  advertisement strobe; fCH_* valid this cycle
- HB_reset  in  1  synchronous round clear (table, count, outputs, FSM)
- HB_CHlimit  in  WORD_WIDTH  max entries accepted this round
- fCH_ID  in  WORD_WIDTH  advertised CH node ID
- fCH_Hops  in  WORD_WIDTH  advertised hop count to sink
- fCH_QValue  in  WORD_WIDTH  advertised Q-value (unsigned)
- chosenCH  out  WORD_WIDTH  selected CH ID
- hopsfromCH  out  WORD_WIDTH  hop count of selected CH
- sel_valid  out  1  one-cycle pulse: new selection on outputs
- adv_dropped  out  1  one-cycle pulse: advertisement discarded
- kch_count  out  IDX_W+1  number of valid entries
- busy  out  1  high in S_COLLECT and S_SCAN

## Operation
- States: S_IDLE, S_COLLECT, S_SCAN. Reset → S_IDLE.
- Reset values: chosenCH 0, hopsfromCH all-ones, sel_valid 0, adv_dropped 0, kch_count 0, busy 0, timer TIMEOUT, all entries invalid.
- Effective limit L = min(HB_CHlimit, CH_DEPTH), evaluated live at each insert.
- Advertisement handling (S_IDLE or S_COLLECT, en_KCH=1):
  - ID matches a valid entry (parallel compare): overwrite Hops and Q; count unchanged.
  - No match, kch_count < L: write at index kch_count; kch_count+1.
  - No match, kch_count ≥ L: discard; adv_dropped pulses next cycle.
  - Any accepted advertisement: timer ← TIMEOUT, state → S_COLLECT.
  - A discard in S_IDLE leaves state in S_IDLE.
- S_COLLECT, en_KCH=0: timer≠0 → timer−1; timer==0 → S_SCAN, scan index ← 0.
- S_SCAN: one entry per cycle, index 0..kch_count−1.
  - Entry 0 loads best unconditionally.
  - Later entries replace best if hops < best.hops; or hops equal and Q > best.Q; or hops and Q equal and ID < best.ID.
  - After the last entry: chosenCH/hopsfromCH ← best, sel_valid pulses, state → S_IDLE, timer ← TIMEOUT.
- en_KCH during S_SCAN: discarded, adv_dropped pulses, scan unaffected.
- Table persists after selection. Later advertisements re-enter S_COLLECT and trigger a fresh selection.
- Outputs hold between selections.
- HB_reset (any state): same values as rst, applied synchronously. Has priority over en_KCH in the same cycle. Aborts a scan without a sel_valid pulse.
- Arithmetic: all comparisons unsigned WORD_WIDTH. Hops all-ones is a legal value. Ties on all three fields are impossible because IDs are unique.

## Timing
- Insert/update is visible in kch_count one cycle after the sampling edge.
- Last advertisement sampled at edge t (table holds N entries): S_SCAN from edge t+TIMEOUT+1. sel_valid is high for the cycle following edge t+TIMEOUT+1+N.
  - Defaults, N=3: sel_valid 19 cycles after t.
- An advertisement in S_COLLECT at any timer value reloads the timer; there is no early selection.
- rst asserted mid-scan: immediate return to reset values. No partial result reaches the outputs.

## Test plan
- Three CHs (ID 5 hops 2 Q 10), (ID 3 hops 1 Q 4), (ID 9 hops 1 Q 4), gap ≥ TIMEOUT+1 → chosenCH 3, hopsfromCH 1, single sel_valid at t+19.
- Hop tie, Q differs: (ID 2 hops 1 Q 7), (ID 8 hops 1 Q 20) → chosenCH 8.
- Update in place: ID 4 hops 3 Q 5, then ID 4 hops 1 Q 5 → kch_count 1, chosenCH 4, hopsfromCH 1.
- Limit: HB_CHlimit 2, four distinct IDs → kch_count 2, adv_dropped pulses on the 3rd and 4th, selection uses only the first two.
- Fill CH_DEPTH with HB_CHlimit 0xFFFF, then one more ID → dropped. An advertisement during S_SCAN → dropped, result unchanged.
- HB_reset during S_SCAN → no sel_valid, kch_count 0, chosenCH 0, hopsfromCH 0xFFFF. rst pulse mid-collect → same values, state S_IDLE.
